// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the SRAM controller.
//   state_t    : controller FSM states
//   calc_beats : SRAM accesses needed per core word
//   log2_floor : floor(log2(v)), used for the byte-to-word address shift
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int calc_beats(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  function automatic int log2_floor(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= v) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_cache.sv
// One-entry read buffer {valid, word-index tag, word} for sram_ctrl_param.
// Only present when SRAM_CTRL_RDCACHE_EN is defined, so plain builds carry
// no buffer registers at all.
// Ports:
//   clk, rst              : clock, async active-high reset (clears valid)
//   lookup_tag / hit      : combinational tag compare against the held entry
//   word                  : held data word
//   fill_en/tag/word      : load a new entry after a read miss completes
//   wt_en/tag/word        : write-through, updates data only on a tag match
`ifdef SRAM_CTRL_RDCACHE_EN
module sram_rd_cache #(
  parameter int TAG_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [DATA_W-1:0] word,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_word,
  input  logic              wt_en,
  input  logic [TAG_W-1:0]  wt_tag,
  input  logic [DATA_W-1:0] wt_word
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      word_q  <= fill_word;
    end else if (wt_en && valid_q && (tag_q == wt_tag)) begin
      word_q  <= wt_word;
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign word = word_q;

endmodule
`endif

// File: rtl/sram_ctrl_param.sv
// SRAM controller: splits each DATA_W core access into DATA_W/SRAM_DQ_W
// beats on an asynchronous SRAM, each beat held for WAIT_CYCLES+1 cycles,
// and returns a one-cycle ready pulse.
// Optional read buffer: define SRAM_CTRL_RDCACHE_EN.
// Ports:
//   clk, rst        : clock, async active-high reset
//   rd_en, wr_en    : held requests (write wins when both are high)
//   address, wdata  : core byte address and write word
//   rdata, ready    : read word (held until next read completes), done pulse
//   SRAM_*          : SRAM pins; UB/LB/CE/OE tied low, WE_N is the strobe
//
// state  | meaning
// IDLE   | waiting for a request; latches address/data/op
// ACCESS | running beats; cnt counts cycles inside the current beat
// DONE   | ready pulse, bus released
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int ADDR_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);

  localparam int BEATS  = calc_beats(DATA_W, SRAM_DQ_W);
  localparam int SHIFT  = log2_floor(DATA_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((DATA_W % SRAM_DQ_W) != 0) begin : g_width_err
    $error("sram_ctrl_param: DATA_W must be a multiple of SRAM_DQ_W");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_err
    $error("sram_ctrl_param: WAIT_CYCLES must be 0..15");
  end

  state_t              state_q, state_nx;
  logic [BEAT_W-1:0]   beat_q;
  logic [3:0]          cnt_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   widx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rd_buf_q;
  logic [DATA_W-1:0]   rd_merge;
  logic [ADDR_W-1:0]   widx_in;
  logic                beat_end;
  logic                last_beat;
  logic                drive;
  logic                cache_hit;
  logic [DATA_W-1:0]   cache_word;

  assign widx_in   = (address - ADDR_W'(BASE_ADDR)) >> SHIFT;
  assign beat_end  = (cnt_q == 4'(WAIT_CYCLES));
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

`ifdef SRAM_CTRL_RDCACHE_EN
  sram_rd_cache #(
    .TAG_W  (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (widx_in),
    .hit        (cache_hit),
    .word       (cache_word),
    .fill_en    (state_q == ACCESS && !op_wr_q && beat_end && last_beat),
    .fill_tag   (widx_q),
    .fill_word  (rd_merge),
    .wt_en      (state_q == IDLE && wr_en),
    .wt_tag     (widx_in),
    .wt_word    (wdata)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    ready    = 1'b0;
    drive    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en)      state_nx = ACCESS;
        else if (rd_en) state_nx = cache_hit ? DONE : ACCESS;
      end
      ACCESS: begin
        drive = op_wr_q;
        if (beat_end && last_beat) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beats land in rd_buf_q; rdata only changes once the whole word is in,
  // so it stays stable for the pipeline between reads.
  always_comb begin
    rd_merge = rd_buf_q;
    rd_merge[beat_q*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q   <= '0;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      rd_buf_q <= '0;
      rdata    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_wr_q <= wr_en;
            widx_q  <= widx_in;
            wdata_q <= wdata;
            beat_q  <= '0;
            cnt_q   <= '0;
            if (!wr_en && cache_hit) rdata <= cache_word;
          end
        end
        ACCESS: begin
          if (beat_end) begin
            cnt_q <= '0;
            if (!op_wr_q) begin
              rd_buf_q <= rd_merge;
              if (last_beat) rdata <= rd_merge;
            end
            if (!last_beat) beat_q <= beat_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SRAM_ADDR = SRAM_ADDR_W'(widx_q * ADDR_W'(BEATS) + ADDR_W'(beat_q));
  assign SRAM_DQ   = drive ? wdata_q[beat_q*SRAM_DQ_W +: SRAM_DQ_W] : 'z;
  assign SRAM_WE_N = ~drive;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_ctrl_param.md
Name: sram_ctrl_param

Overview:
Parametrised SRAM controller bridging the core's single-word memory stage to an external asynchronous 16-bit SRAM.
- Splits each DATA_W word into BEATS = DATA_W/SRAM_DQ_W sequential SRAM accesses.
- Each beat is stretched by a configurable number of wait cycles.
- Returns a one-cycle ready pulse the pipeline uses to release its freeze.
- Sits between the MEM stage and the board SRAM pins; the bench pairs it with the SRAM behavioural model.

Parameters:
DATA_W, 32, core data word width; must be an integer multiple of SRAM_DQ_W (elaboration error otherwise)
SRAM_DQ_W, 16, SRAM data bus width
SRAM_ADDR_W, 18, SRAM address width
ADDR_W, 32, core byte-address width
BASE_ADDR, 1024, core byte address mapped to SRAM word 0
WAIT_CYCLES, 1, extra cycles per beat (0..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_en  in  1  read request, held until ready
wr_en  in  1  write request, held until ready; wins if both high
address  in  ADDR_W  core byte address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid while ready=1, held until the next read completes
ready  out  1  one-cycle completion pulse
SRAM_DQ  inout  SRAM_DQ_W  SRAM data bus
SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address
SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  constant 0
SRAM_WE_N  out  1  write strobe, active low

Behaviour:
- Reset state: IDLE, beat=0, cnt=0, rdata=0, ready=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
- Assertion of rst at any time, including mid-beat, aborts immediately. No ready pulse is issued, and SRAM contents for the aborted word are undefined.
- Word index: widx = (address - BASE_ADDR) >> log2(DATA_W/8). SRAM_ADDR = widx*BEATS + beat, truncated to SRAM_ADDR_W.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If wr_en|rd_en at an edge, latch address, wdata and op (write if wr_en).
  - beat=0, cnt=0, go to ACCESS.
- ACCESS:
  - Drive SRAM_ADDR for the current beat.
  - Write: SRAM_DQ = wdata slice [beat*SRAM_DQ_W +: SRAM_DQ_W] and SRAM_WE_N=0 for every cycle of the beat.
  - Read: SRAM_DQ=Z, SRAM_WE_N=1.
  - cnt increments each cycle. When cnt==WAIT_CYCLES:
    - Read: capture SRAM_DQ into rdata slice beat.
    - cnt=0. If beat==BEATS-1 go to DONE, else beat++.
  - Beat 0 is the least-significant half.
- DONE: ready=1 for exactly one cycle, SRAM_WE_N=1, DQ=Z, then IDLE.
- Latency: ready is high BEATS*(WAIT_CYCLES+1) cycles after the sampling edge (defaults: 4).
- Requester must drop its request on the cycle it sees ready. A request still high in IDLE is treated as a new request.
- If a request drops during ACCESS, the operation still completes and ready still pulses.
- rdata is unchanged by writes.

Optional Feature:
SRAM_CTRL_RDCACHE_EN
- With it: one-entry read buffer holding {valid, widx tag, word}.
  - A read in IDLE with valid && tag==widx skips ACCESS and goes straight to DONE, so ready is high 1 cycle after sampling; rdata is loaded from the buffer.
  - A read miss fills the buffer.
  - A write to the matching widx updates the buffer data (write-through).
  - Reset clears valid.
- Without it: every read takes full SRAM latency; no buffer registers exist.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, ACCESS, DONE) and a BEATS/log2 helper function.
- Optional sub-module sram_rd_cache: the read buffer, instantiated only under the macro.
- Beat/wait counters stay in the top module.

Test Plan:
- Write 0xDEADBEEF at 1024 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; SRAM_WE_N low for 4 cycles; ready after 4 cycles.
- Read 1024 after the above → rdata=0xDEADBEEF with ready; read 1028 → SRAM_ADDR 2 then 3.
- WAIT_CYCLES=0, DATA_W=64 → 4 beats of 1 cycle each, ready 4 cycles after request; WAIT_CYCLES=3 → each address held 4 cycles.
- rd_en and wr_en both high → write performed, rdata unchanged.
- rst pulsed mid-beat during a write → SRAM_WE_N=1 and DQ=Z immediately, no ready pulse, state IDLE, next read works normally.
- With SRAM_CTRL_RDCACHE_EN: two reads of 1032 → second ready 1 cycle after request; write 0x12345678 to 1032, then read → 0x12345678 in 1 cycle.
